// File: rtl/ifc_call_arbiter_if.sv
// Requester/resource bundle for the shared call arbiter.
// master: requesters plus the resource model; slave: the arbiter.
interface ifc_call_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_arg;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               call_valid;
    logic [DW-1:0]      call_arg;
    logic               call_ready;
    logic               call_done;
    logic [DW-1:0]      call_result;

    modport master (
        output req, req_arg, lock, call_ready, call_done, call_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, call_valid, call_arg
    );

    modport slave (
        input  req, req_arg, lock, call_ready, call_done, call_result,
        output gnt, rsp_valid, rsp_data, rsp_err, call_valid, call_arg
    );
endinterface

// File: rtl/ifc_call_arbiter.sv
// Round-robin arbiter sharing one exported-function resource among NREQ requesters.
// Optional IFC_ARB_LOCK_EN: lock hint re-grants the same requester up to 4 times in a row.
module ifc_call_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst_n,
    ifc_call_arbiter_if.slave bus
);
    localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW       = 8;
    localparam int unsigned LOCK_MAX = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   id_q, id_d, last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d, rspv_q, rspv_d;
    logic [DW-1:0]   rdata_q, rdata_d, carg_q, carg_d;
    logic            rerr_q, rerr_d, cvalid_q, cvalid_d;

    logic            rr_found;
    logic [IW-1:0]   rr_id, rr_idx;
    logic            pick_valid;
    logic [IW-1:0]   pick_id;
    logic [DW-1:0]   pick_arg;

    // First requesting index after the last grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = last_q;
        rr_idx   = last_q;
        for (int k = 1; k <= int'(NREQ); k++) begin
            rr_idx = IW'((int'(last_q) + k) % int'(NREQ));
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found = 1'b1;
                rr_id    = rr_idx;
            end
        end
    end

`ifdef IFC_ARB_LOCK_EN
    logic       lock_q, lock_d;
    logic [2:0] run_q, run_d;

    always_comb begin
        pick_valid = rr_found;
        pick_id    = rr_id;
        if (lock_q && bus.req[last_q]) begin
            pick_valid = 1'b1;
            pick_id    = last_q;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;

    always_comb begin
        pick_valid = rr_found;
        pick_id    = rr_id;
    end
`endif

    always_comb begin
        pick_arg = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IW'(i) == pick_id) pick_arg = bus.req_arg[i*DW +: DW];
        end
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        rspv_d   = '0;
        rdata_d  = rdata_q;
        rerr_d   = 1'b0;
        cvalid_d = cvalid_q;
        carg_d   = carg_q;
`ifdef IFC_ARB_LOCK_EN
        lock_d   = lock_q;
        run_d    = run_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d     = pick_id;
                    gnt_d    = NREQ'(1) << pick_id;
                    cvalid_d = 1'b1;
                    carg_d   = pick_arg;
                    state_d  = ISSUE;
`ifdef IFC_ARB_LOCK_EN
                    lock_d   = 1'b0;
                    run_d    = (pick_id == last_q) ?
                               ((run_q < 3'(LOCK_MAX)) ? run_q + 3'd1 : run_q) : 3'd1;
`endif
                end
            end
            ISSUE: begin
                if (bus.call_ready) begin
                    cvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.call_done || cnt_q == CW'(TIMEOUT - 1)) begin
                    rspv_d  = NREQ'(1) << id_q;
                    rdata_d = bus.call_done ? bus.call_result : '0;
                    rerr_d  = !bus.call_done;
                    gnt_d   = '0;
                    last_d  = id_q;
                    state_d = IDLE;
`ifdef IFC_ARB_LOCK_EN
                    lock_d  = bus.lock[id_q] && (run_q < 3'(LOCK_MAX));
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            last_q   <= IW'(NREQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            rspv_q   <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            cvalid_q <= 1'b0;
            carg_q   <= '0;
`ifdef IFC_ARB_LOCK_EN
            lock_q   <= 1'b0;
            run_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rspv_q   <= rspv_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            cvalid_q <= cvalid_d;
            carg_q   <= carg_d;
`ifdef IFC_ARB_LOCK_EN
            lock_q   <= lock_d;
            run_q    <= run_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rspv_q;
    assign bus.rsp_data   = rdata_q;
    assign bus.rsp_err    = rerr_q;
    assign bus.call_valid = cvalid_q;
    assign bus.call_arg   = carg_q;
endmodule
